// File: rtl/demux8_deser.sv
// Serial 1:8 deserializer: per-channel shift/count, one-deep word buffer, round-robin drain to a registered output.
// Final bit -> buffer next cycle -> output the cycle after; only a final bit into a full, non-draining buffer stalls.
module demux8_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_data,
  input  logic [2:0]       in_sel,
  output logic             in_ready,
  output logic             out_valid,
  output logic [2:0]       out_ch,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [7:0]       ch_busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // The MSB of the shift register is never observed, so only WIDTH-1 bits are kept.
  logic [WIDTH-2:0] r_sr     [8];
  logic [CW-1:0]    r_cnt    [8];
  logic [WIDTH-1:0] r_hold   [8];
  logic [7:0]       r_hold_v;

  logic             r_out_valid;
  logic [2:0]       r_out_ch;
  logic [WIDTH-1:0] r_out_data;
  logic [2:0]       r_rr_ptr;

  logic [2:0]       w_grant;
  logic             w_found;
  logic             w_load;
  logic             w_final;
  logic             w_accept;
  logic [WIDTH-1:0] w_word;

  always_comb begin
    w_grant = r_rr_ptr;
    w_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!w_found && r_hold_v[r_rr_ptr + 3'(i)]) begin
        w_grant = r_rr_ptr + 3'(i);
        w_found = 1'b1;
      end
    end
  end

  assign w_load   = (!r_out_valid || out_ready) && (|r_hold_v);
  assign w_final  = (r_cnt[in_sel] == LAST);
  assign w_word   = {r_sr[in_sel], in_data};
  // A buffer being drained this cycle can take the new word in the same edge.
  assign in_ready = !(w_final && r_hold_v[in_sel] && !(w_load && (w_grant == in_sel)));
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 8; c++) begin
        r_sr[c]   <= '0;
        r_cnt[c]  <= '0;
        r_hold[c] <= '0;
      end
      r_hold_v <= '0;
    end else begin
      if (w_load) begin
        r_hold_v[w_grant] <= 1'b0;
      end
      // Later assignment wins, so a simultaneous refill keeps the buffer valid.
      if (w_accept) begin
        r_sr[in_sel] <= w_word[WIDTH-2:0];
        if (w_final) begin
          r_cnt[in_sel]    <= '0;
          r_hold[in_sel]   <= w_word;
          r_hold_v[in_sel] <= 1'b1;
        end else begin
          r_cnt[in_sel] <= r_cnt[in_sel] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_ch    <= w_grant;
      r_out_data  <= r_hold[w_grant];
      r_rr_ptr    <= w_grant + 3'd1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_comb begin
    ch_busy = '0;
    for (int c = 0; c < 8; c++) begin
      ch_busy[c] = (r_cnt[c] != '0) | r_hold_v[c];
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_data  = r_out_data;

endmodule
